msdap_conv_engine: RTL and testbench

// - NCH-channel sparse-coefficient convolution core; parametrised successor of the fixed L/R MSDAP datapath.
// - Accepts one parallel sample per channel from the S2P side.
// - Computes y(n) per channel from per-channel Rj/coefficient tables and a sample history.
// - Hands 40-bit results to the P2S side over a valid/ready handshake.

---
 rtl/msdap_pkg.sv | 20 ++
 rtl/msdap_conv_lane.sv | 92 +++++++++
 rtl/msdap_conv_engine.sv | 169 ++++++++++++++++
 tb/tb_msdap_conv_engine.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/msdap_pkg.sv
// Shared types and constants for the MSDAP sparse-coefficient convolution engine.
package msdap_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ACCUM = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic CFG_SEL_RJ    = 1'b0;
  localparam logic CFG_SEL_COEFF = 1'b1;

  // Coefficient word layout: {sign, unused, delay k}; sign sits at the top of a 16-bit word.
  localparam int COEFF_SIGN_BIT = 15;
  localparam int FRAC_SHIFT     = 16;
  localparam int SLEEP_LEN      = 800;

endpackage

// File: rtl/msdap_conv_lane.sv
// One convolution channel: Rj table, coefficient table, sample history and accumulator.
// Sequencing comes from the shared FSM in msdap_conv_engine; all lanes run in lockstep.
module msdap_conv_lane
  import msdap_pkg::*;
#(
  parameter int DW     = 16,
  parameter int AW     = 40,
  parameter int NRJ    = 16,
  parameter int NCOEFF = 512,
  parameter int DEPTH  = 256,
  localparam int RJW   = $clog2(NRJ),
  localparam int CAW   = $clog2(NCOEFF),
  localparam int HAW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rj_we,
  input  logic                 coeff_we,
  input  logic [CAW-1:0]       cfg_addr,
  input  logic [DW-1:0]        cfg_wdata,
  input  logic                 hist_we,
  input  logic [HAW-1:0]       wptr,
  input  logic signed [DW-1:0] sample,
  input  logic [HAW:0]         count,
  input  logic                 start,
  input  logic                 fetch,
  input  logic                 accum,
  input  logic                 shift,
  input  logic [RJW-1:0]       j,
  output logic [DW-1:0]        rj,
  output logic signed [AW-1:0] acc
);

  logic [DW-1:0]        rj_mem    [NRJ];
  logic [DW-1:0]        coeff_mem [NCOEFF];
  logic signed [DW-1:0] hist_mem  [DEPTH];

  logic [CAW-1:0]       p, p_nxt;
  logic [DW-1:0]        r_lane;
  logic [DW-1:0]        coeff_p1;
  logic                 active;
  logic [HAW-1:0]       k;
  logic [HAW-1:0]       hidx;
  logic signed [DW-1:0] x;
  logic                 unused_bits;

  function automatic logic signed [AW-1:0] coeff_term(input logic signed [DW-1:0] xs,
                                                      input logic neg);
    logic signed [AW-1:0] xe;
    xe = {{(AW-DW){xs[DW-1]}}, xs} <<< FRAC_SHIFT;
    return neg ? -xe : xe;
  endfunction

  always_ff @(posedge clk) begin
    if (rj_we)    rj_mem[cfg_addr[RJW-1:0]] <= cfg_wdata;
    if (coeff_we) coeff_mem[cfg_addr]       <= cfg_wdata;
    if (hist_we)  hist_mem[wptr]            <= sample;
  end

  assign rj     = rj_mem[j];
  assign active = accum && (r_lane != '0);
  // A lane whose own Rj is shorter than the shared group length just idles.
  assign p_nxt  = start ? '0 : (active ? p + 1'b1 : p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p      <= '0;
      r_lane <= '0;
    end else begin
      p <= p_nxt;
      if (fetch)       r_lane <= rj;
      else if (active) r_lane <= r_lane - 1'b1;
    end
  end

  // Stage p1: coefficient word registered from the next pointer value
  always_ff @(posedge clk) begin
    coeff_p1 <= coeff_mem[p_nxt];
  end

  assign k           = coeff_p1[HAW-1:0];
  assign hidx        = wptr - 1'b1 - k;
  assign x           = ({1'b0, k} >= count) ? '0 : hist_mem[hidx];
  assign unused_bits = ^coeff_p1[COEFF_SIGN_BIT-1:HAW];

  always_ff @(posedge clk) begin
    if (start)       acc <= '0;
    else if (active) acc <= acc + coeff_term(x, coeff_p1[COEFF_SIGN_BIT]);
    else if (shift)  acc <= acc >>> 1;
  end

endmodule

// File: rtl/msdap_conv_engine.sv
// NCH-lane sparse-coefficient convolution engine with shared FSM and valid/ready result port.
// Optional zero-input sleep is built when MSDAP_ZERO_SLEEP_EN is defined.
module msdap_conv_engine
  import msdap_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DW     = 16,
  parameter int AW     = 40,
  parameter int NRJ    = 16,
  parameter int NCOEFF = 512,
  parameter int DEPTH  = 256,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CAW   = $clog2(NCOEFF),
  localparam int RJW   = $clog2(NRJ),
  localparam int HAW   = $clog2(DEPTH)
) (
  input  logic              Sclk,
  input  logic              Reset_n,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [CAW-1:0]    cfg_addr,
  input  logic [DW-1:0]     cfg_wdata,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH*DW-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH*AW-1:0] out_data,
  output logic              sleep
);

  localparam logic [HAW:0]   DEPTH_CNT = (HAW+1)'(DEPTH);
  localparam logic [RJW-1:0] J_LAST    = RJW'(NRJ - 1);

  state_t                state, state_nxt;
  logic [RJW-1:0]        j;
  logic [DW-1:0]         r;
  logic [HAW-1:0]        wptr;
  logic [HAW:0]          count;
  logic                  accept, cfg_ok, load_out, sleep_skip;
  logic                  fetch_en, accum_en, shift_en;
  logic [DW-1:0]         rj_max;
  logic [DW-1:0]         rj_lane  [NCH];
  logic signed [AW-1:0]  acc_lane [NCH];

  assign accept   = in_valid && in_ready;
  assign cfg_ok   = cfg_we && (state == IDLE);
  assign load_out = (state == DONE) && !out_valid;

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = sleep_skip ? DONE : FETCH;
      FETCH:   state_nxt = (rj_max == '0) ? SHIFT : ACCUM;
      ACCUM:   if (r == DW'(1)) state_nxt = SHIFT;
      SHIFT:   state_nxt = (j == J_LAST) ? DONE : FETCH;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    fetch_en = (state == FETCH);
    accum_en = (state == ACCUM);
    shift_en = (state == SHIFT);
  end

  // Group length follows the longest Rj among the lanes so they stay in lockstep.
  always_comb begin
    rj_max = '0;
    for (int c = 0; c < NCH; c++)
      if (rj_lane[c] > rj_max) rj_max = rj_lane[c];
  end

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      j       <= '0;
      r       <= '0;
      wptr    <= '0;
      count   <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (accept) begin
        j    <= '0;
        wptr <= wptr + 1'b1;
        if (count != DEPTH_CNT) count <= count + 1'b1;
      end
      if (fetch_en)      r <= rj_max;
      else if (accum_en) r <= r - 1'b1;
      if (shift_en)      j <= j + 1'b1;
      if (cfg_we && state != IDLE) cfg_err <= 1'b1;
    end
  end

  // Output stage: result captured on the first DONE cycle and held until taken
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      for (int c = 0; c < NCH; c++) out_data[c*AW +: AW] <= acc_lane[c];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MSDAP_ZERO_SLEEP_EN
  localparam int           ZW        = $clog2(SLEEP_LEN + 1);
  localparam logic [ZW-1:0] SLEEP_CNT = ZW'(SLEEP_LEN);

  logic          zero_vec;
  logic [ZW-1:0] zcnt;

  assign zero_vec   = (in_data == '0);
  assign sleep_skip = sleep && zero_vec;

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      zcnt  <= '0;
      sleep <= 1'b0;
    end else if (accept) begin
      if (zero_vec) begin
        if (zcnt != SLEEP_CNT) zcnt <= zcnt + 1'b1;
        if (zcnt >= SLEEP_CNT - 1'b1) sleep <= 1'b1;
      end else begin
        zcnt  <= '0;
        sleep <= 1'b0;
      end
    end
  end
`else
  assign sleep      = 1'b0;
  assign sleep_skip = 1'b0;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    msdap_conv_lane #(
      .DW(DW), .AW(AW), .NRJ(NRJ), .NCOEFF(NCOEFF), .DEPTH(DEPTH)
    ) u_lane (
      .clk       (Sclk),
      .rst_n     (Reset_n),
      .rj_we     (cfg_ok && (cfg_sel == CFG_SEL_RJ) && (cfg_ch == CHW'(c))),
      .coeff_we  (cfg_ok && (cfg_sel == CFG_SEL_COEFF) && (cfg_ch == CHW'(c))),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .hist_we   (accept),
      .wptr      (wptr),
      .sample    (in_data[c*DW +: DW]),
      .count     (count),
      .start     (accept),
      .fetch     (fetch_en),
      .accum     (accum_en),
      .shift     (shift_en),
      .j         (j),
      .rj        (rj_lane[c]),
      .acc       (acc_lane[c])
    );
  end

endmodule

// File: tb/tb_msdap_conv_engine.sv
// Directed bench for msdap_conv_engine: latency, sign, delay taps, backpressure, config errors, reset.
module tb_msdap_conv_engine;

  logic        Sclk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [0:0]  cfg_ch = '0;
  logic [8:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        cfg_err;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [79:0] out_data;
  logic        sleep;

  int          total = 0;
  int          bad = 0;
  int          lat;
  logic [39:0] o0, o1;

  msdap_conv_engine dut (
    .Sclk(Sclk), .Reset_n(Reset_n),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sleep(sleep)
  );

  always #5 Sclk = ~Sclk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic sel, input logic ch, input int addr, input logic [15:0] data);
    cfg_sel   = sel;
    cfg_ch    = ch;
    cfg_addr  = 9'(addr);
    cfg_wdata = data;
    cfg_we    = 1'b1;
    @(posedge Sclk); #1;
    cfg_we    = 1'b0;
  endtask

  task automatic set_rj(input logic [15:0] r0, input logic [15:0] r15);
    for (int ch = 0; ch < 2; ch++)
      for (int a = 0; a < 16; a++)
        cfg_write(1'b0, ch[0], a, (a == 0) ? r0 : ((a == 15) ? r15 : 16'h0000));
  endtask

  task automatic set_coef(input int addr, input logic [15:0] data);
    cfg_write(1'b1, 1'b0, addr, data);
    cfg_write(1'b1, 1'b1, addr, data);
  endtask

  task automatic await_out(input int from, output int l, output logic [39:0] a, output logic [39:0] b);
    l = 0;
    for (int i = from; i <= 3000; i++) begin
      @(negedge Sclk);
      if (out_valid) begin
        l = i;
        break;
      end
      @(posedge Sclk); #1;
    end
    a = out_data[39:0];
    b = out_data[79:40];
  endtask

  task automatic run(input logic [15:0] d0, input logic [15:0] d1, input int hold,
                     output int l, output logic [39:0] a, output logic [39:0] b);
    out_ready = (hold == 0);
    in_data   = {d1, d0};
    in_valid  = 1'b1;
    @(posedge Sclk); #1;
    in_valid  = 1'b0;
    await_out(1, l, a, b);
    for (int h = 0; h < hold; h++) begin
      @(posedge Sclk); #1;
      in_valid = 1'b1;
      in_data  = 32'h7FFF_7FFF;
      @(negedge Sclk);
      check("bp_valid", 80'(out_valid), 80'(1));
      check("bp_data", out_data, {b, a});
      check("bp_in_ready", 80'(in_ready), 80'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge Sclk); #1;
  endtask

  initial begin
    repeat (2) @(posedge Sclk);
    @(negedge Sclk);
    check("rst_out_valid", 80'(out_valid), 80'(0));
    check("rst_in_ready", 80'(in_ready), 80'(1));
    check("rst_out_data", out_data, 80'(0));
    check("rst_cfg_err", 80'(cfg_err), 80'(0));
    check("rst_sleep", 80'(sleep), 80'(0));
    @(posedge Sclk); #1;
    Reset_n = 1'b1;
    @(posedge Sclk); #1;

    // Single tap, positive coefficient, k=0
    set_rj(16'd1, 16'd0);
    set_coef(0, 16'h0000);
    run(16'h4000, 16'hF000, 0, lat, o0, o1);
    check("pos_latency", 80'(lat), 80'(35));
    check("pos_lane0", 80'(o0), 80'(40'h00_0000_4000));
    check("pos_lane1", 80'(o1), 80'(40'hFF_FFFF_F000));

    // Sign bit set
    set_coef(0, 16'h8000);
    run(16'h4000, 16'hF000, 0, lat, o0, o1);
    check("neg_latency", 80'(lat), 80'(35));
    check("neg_lane0", 80'(o0), 80'(40'hFF_FFFF_C000));
    check("neg_lane1", 80'(o1), 80'(40'h00_0000_1000));

    // Backpressure for 5 cycles with in_valid asserted meanwhile
    set_coef(0, 16'h0000);
    run(16'h0100, 16'h0200, 5, lat, o0, o1);
    check("bp_lane0", 80'(o0), 80'(40'h00_0000_0100));
    check("bp_lane1", 80'(o1), 80'(40'h00_0000_0200));

    // Config write during ACCUM is dropped and flagged
    in_data  = {16'h4000, 16'h4000};
    in_valid = 1'b1;
    @(posedge Sclk); #1;
    in_valid = 1'b0;
    @(posedge Sclk); #1;
    cfg_sel = 1'b1; cfg_ch = 1'b0; cfg_addr = 9'd0; cfg_wdata = 16'h8000; cfg_we = 1'b1;
    @(posedge Sclk); #1;
    cfg_we = 1'b0;
    await_out(3, lat, o0, o1);
    check("cfgbusy_latency", 80'(lat), 80'(35));
    check("cfgbusy_lane0", 80'(o0), 80'(40'h00_0000_4000));
    check("cfgbusy_err", 80'(cfg_err), 80'(1));
    @(posedge Sclk); #1;
    run(16'h4000, 16'h4000, 0, lat, o0, o1);
    check("cfgbusy_rerun_lane0", 80'(o0), 80'(40'h00_0000_4000));
    check("cfgbusy_rerun_lane1", 80'(o1), 80'(40'h00_0000_4000));
    check("cfgbusy_err_sticky", 80'(cfg_err), 80'(1));

    // Reset asserted mid-ACCUM
    in_data  = {16'h1234, 16'h1234};
    in_valid = 1'b1;
    @(posedge Sclk); #1;
    in_valid = 1'b0;
    @(posedge Sclk); #1;
    Reset_n = 1'b0;
    @(negedge Sclk);
    check("midrst_out_valid", 80'(out_valid), 80'(0));
    check("midrst_in_ready", 80'(in_ready), 80'(1));
    check("midrst_out_data", out_data, 80'(0));
    check("midrst_cfg_err", 80'(cfg_err), 80'(0));
    @(posedge Sclk); #1;
    Reset_n = 1'b1;
    @(posedge Sclk); #1;

    // Delay tap k=2 against a fresh history; Rj retained across reset
    set_coef(0, 16'h0002);
    run(16'h1000, 16'h0800, 0, lat, o0, o1);
    check("k2_s0_lane0", 80'(o0), 80'(0));
    check("k2_s0_lane1", 80'(o1), 80'(0));
    run(16'h0000, 16'h0000, 0, lat, o0, o1);
    check("k2_s1_lane0", 80'(o0), 80'(0));
    check("k2_s1_lane1", 80'(o1), 80'(0));
    run(16'h0000, 16'h0000, 0, lat, o0, o1);
    check("k2_s2_lane0", 80'(o0), 80'(40'h00_0000_1000));
    check("k2_s2_lane1", 80'(o1), 80'(40'h00_0000_0800));

    // Taps in the first and last shift groups
    set_rj(16'd1, 16'd1);
    set_coef(0, 16'h0000);
    set_coef(1, 16'h0000);
    run(16'h4000, 16'h0001, 0, lat, o0, o1);
    check("grp_latency", 80'(lat), 80'(36));
    check("grp_lane0", 80'(o0), 80'(40'h00_2000_4000));
    check("grp_lane1", 80'(o1), 80'(40'h00_0000_8001));

`ifdef MSDAP_ZERO_SLEEP_EN
    set_rj(16'd0, 16'd0);
    for (int n = 1; n <= 800; n++) begin
      run(16'h0000, 16'h0000, 0, lat, o0, o1);
      if (n == 799) check("sleep_before", 80'(sleep), 80'(0));
    end
    check("sleep_after_800", 80'(sleep), 80'(1));
    run(16'h0000, 16'h0000, 0, lat, o0, o1);
    check("sleep_latency", 80'(lat), 80'(2));
    check("sleep_result", {o1, o0}, 80'(0));
    run(16'h0001, 16'h0000, 0, lat, o0, o1);
    check("wake_sleep", 80'(sleep), 80'(0));
    check("wake_latency", 80'(lat), 80'(34));
`else
    check("sleep_tied_low", 80'(sleep), 80'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
